reg_access_arbiter: RTL and testbench
=====================================

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, register data width in bits.
REQ-002 Parameter NUM_REGS, default 8, number of registers in the bank.
REQ-003 Parameter ADDR_W, default 3, register address width; NUM_REGS SHALL be <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  2  per-requester access request, bit i = requester i.
REQ-007 we  input  2  per-requester write enable; 1 = write, 0 = read.
REQ-008 addr  input  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  input  2*WORD_SIZE  requester i write data in bits [i*WORD_SIZE +: WORD_SIZE].
REQ-010 gnt  output  2  one-hot-or-zero grant, combinational from req and priority state.
REQ-011 rvalid  output  2  read data valid for requester i, registered.
REQ-012 rdata  output  WORD_SIZE  shared read data, registered, qualified by rvalid.

Function
REQ-013 The block SHALL own a NUM_REGS x WORD_SIZE register bank and grant at most one access per cycle.
REQ-014 gnt SHALL be zero when req is zero; with one bit of req set, that requester SHALL be granted.
REQ-015 With both req bits set, the requester indicated by the priority state SHALL be granted.
REQ-016 Priority state SHALL be a 2-state machine PRI0/PRI1; after a grant to requester i it SHALL move to the other requester's state; no grant, no transition.
REQ-017 A granted write SHALL update bank[addr_i] with wdata_i at the same rising edge.
REQ-018 A granted read SHALL drive rdata = bank[addr_i] and rvalid[i] = 1 in the cycle after grant (latency 1); otherwise rvalid = 0 and rdata holds its last value.
REQ-019 A read granted the cycle after a write to the same address SHALL return the newly written data.
REQ-020 Requesters SHALL hold req, we, addr, wdata stable until gnt; req may drop without grant with no side effect.
REQ-021 Address >= NUM_REGS: write SHALL be discarded, read SHALL return rdata = 0 with rvalid asserted normally.
REQ-022 Consecutive grants to one requester SHALL be possible when the other is not requesting; throughput 1 access/cycle.

Reset
REQ-023 rst asserted SHALL immediately clear all bank registers, rdata, rvalid to 0 and priority state to PRI0.
REQ-024 During rst gnt SHALL be 0; an access granted in the cycle reset asserts SHALL be dropped (no write, no rvalid).
REQ-025 First grant after rst deassertion with both requesting SHALL go to requester 0.

Configuration
REQ-026 Macro REG_ARB_ROUND_ROBIN_EN defined: priority per REQ-015/REQ-016 (round-robin).
REQ-027 Macro undefined: fixed priority, requester 0 always wins contention; priority state SHALL be absent and REQ-025 trivially holds.

Structure
REQ-028 Shared package reg_arb_pkg SHALL hold WORD_SIZE/NUM_REGS/ADDR_W defaults and the PRI0/PRI1 state encoding.
REQ-029 Bank storage SHALL be a sub-module reg_bank (write port, one read port, async clear); arbiter FSM and read pipeline SHALL stay in reg_access_arbiter.

Verification
REQ-030 Reset, then req=01 we=01 addr0=2 wdata0=0xDEADBEEF; next cycle req=01 we=00 addr0=2 -> gnt=01 both cycles, following cycle rvalid=01 rdata=0xDEADBEEF.
REQ-031 ROUND_ROBIN_EN, both requesting reads of addr 1 continuously for 4 cycles -> gnt sequence 01,10,01,10; rvalid one cycle delayed matching.
REQ-032 Without macro, same stimulus as REQ-031 -> gnt=01 all 4 cycles, requester 1 starved.
REQ-033 Write addr 9 value 0x1234 then read addr 9 (NUM_REGS=8, ADDR_W=4) -> rvalid asserted, rdata=0; bank contents unchanged.
REQ-034 Write 0x55 to addr 3, assert rst for 1 cycle mid-stream with pending read -> rvalid=0, gnt=0 during reset; post-reset read addr 3 returns 0.
REQ-035 req1 asserted, dropped before grant while req0 active -> no write occurs to requester 1 address; priority state unaffected by the withdrawn request.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the two-requester register access arbiter:
//   - default bank geometry (word width, register count, address width)
//   - priority state encoding used by the round-robin arbiter
//   - helper to size the internal register index
// No ports (package).
// -----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int REG_ARB_WORD_SIZE = 32;
    localparam int REG_ARB_NUM_REGS  = 8;
    localparam int REG_ARB_ADDR_W    = 3;

    // PRI0: requester 0 wins contention; PRI1: requester 1 wins contention.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_state_t;

    // Width of an index that spans n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// NUM_REGS x WORD_SIZE register storage with one write port and one
// combinational read port. Addresses at or above NUM_REGS are treated as
// holes: writes to them are discarded and reads from them return zero.
// All registers clear asynchronously on rst.
//
// Ports:
//   clk      in   clock, writes on rising edge
//   rst      in   asynchronous active-high clear of every register
//   wr_en    in   write strobe
//   wr_addr  in   write address [ADDR_W]
//   wr_data  in   write data [WORD_SIZE]
//   rd_addr  in   read address [ADDR_W]
//   rd_data  out  read data [WORD_SIZE], combinational
// -----------------------------------------------------------------------------
module reg_bank
    import reg_arb_pkg::*;
#(
    parameter int WORD_SIZE = REG_ARB_WORD_SIZE,
    parameter int NUM_REGS  = REG_ARB_NUM_REGS,
    parameter int ADDR_W    = REG_ARB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    localparam int IDX_W = idx_width(NUM_REGS);

    logic                 wr_hit;
    logic                 rd_hit;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [WORD_SIZE-1:0] reg_vec [NUM_REGS];

    // The full address is range-checked; only the low bits select the entry.
    assign wr_hit = wr_en && (32'(wr_addr) < NUM_REGS);
    assign rd_hit = (32'(rd_addr) < NUM_REGS);
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [WORD_SIZE-1:0] word_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                word_q <= '0;
            end else if (wr_hit && (wr_idx == IDX_W'(gi))) begin
                word_q <= wr_data;
            end
        end

        assign reg_vec[gi] = word_q;
    end

    assign rd_data = rd_hit ? reg_vec[rd_idx] : '0;

endmodule

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
// Two requesters share one register bank; at most one access is granted per
// cycle. Grants are combinational from req and the priority state; a granted
// write lands in the bank on the same rising edge, a granted read returns its
// data one cycle later on the shared rdata bus, qualified by rvalid[i].
//
// Build option:
//   REG_ARB_ROUND_ROBIN_EN defined   -> round-robin contention (PRI0/PRI1 FSM)
//   REG_ARB_ROUND_ROBIN_EN undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   req     in   [2] access request per requester
//   we      in   [2] write enable per requester (1 = write, 0 = read)
//   addr    in   [2*ADDR_W] requester i address at [i*ADDR_W +: ADDR_W]
//   wdata   in   [2*WORD_SIZE] requester i data at [i*WORD_SIZE +: WORD_SIZE]
//   gnt     out  [2] one-hot-or-zero grant, combinational
//   rvalid  out  [2] registered read-data valid per requester
//   rdata   out  [WORD_SIZE] registered shared read data
// -----------------------------------------------------------------------------
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WORD_SIZE = REG_ARB_WORD_SIZE,
    parameter int NUM_REGS  = REG_ARB_NUM_REGS,
    parameter int ADDR_W    = REG_ARB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [2*ADDR_W-1:0]    addr,
    input  logic [2*WORD_SIZE-1:0] wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             rvalid,
    output logic [WORD_SIZE-1:0]   rdata
);

    // Per-requester views of the packed address and data buses.
    logic [ADDR_W-1:0]    addr_arr  [2];
    logic [WORD_SIZE-1:0] wdata_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata[gi*WORD_SIZE +: WORD_SIZE];
    end

    // -------------------------------------------------------------------------
    // Contention resolution
    // -------------------------------------------------------------------------
    logic contend_pick1;

`ifdef REG_ARB_ROUND_ROBIN_EN
    pri_state_t pri_q;

    // Whoever was granted last yields on the next contention. Cycles without
    // a grant (including a withdrawn request) leave the state alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= PRI0;
        end else begin
            case (pri_q)
                PRI0: if (gnt[0]) pri_q <= PRI1;
                      else if (gnt[1]) pri_q <= PRI0;
                PRI1: if (gnt[1]) pri_q <= PRI0;
                      else if (gnt[0]) pri_q <= PRI1;
                default: pri_q <= PRI0;
            endcase
        end
    end

    assign contend_pick1 = (pri_q == PRI1);
`else
    assign contend_pick1 = 1'b0;
`endif

    // Held at zero throughout reset so nothing is accepted while clearing.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = contend_pick1 ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Access steering into the bank
    // -------------------------------------------------------------------------
    logic                 sel;
    logic                 acc_wr;
    logic [ADDR_W-1:0]    acc_addr;
    logic [WORD_SIZE-1:0] acc_wdata;
    logic [WORD_SIZE-1:0] bank_rd;

    assign sel       = gnt[1];
    assign acc_addr  = addr_arr[sel];
    assign acc_wdata = wdata_arr[sel];
    assign acc_wr    = (|gnt) && we[sel];

    reg_bank #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc_wr),
        .wr_addr (acc_addr),
        .wr_data (acc_wdata),
        .rd_addr (acc_addr),
        .rd_data (bank_rd)
    );

    // -------------------------------------------------------------------------
    // Read return pipeline (one cycle)
    // -------------------------------------------------------------------------
    logic [1:0]           rvalid_d, rvalid_q;
    logic [WORD_SIZE-1:0] rdata_d,  rdata_q;

    // gnt is one-hot, so masking with ~we flags exactly the granted read.
    assign rvalid_d = gnt & ~we;
    assign rdata_d  = (|rvalid_d) ? bank_rd : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
// Drives the arbiter with a table of per-cycle vectors (expected grant listed
// for both priority modes), then hand-written reset and withdrawn-request
// sequences. Expected read responses come from a bench-side bank model and
// are queued at drive time, then popped once the DUT has registered its
// response.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

    localparam int WS = 32;
    localparam int NR = 8;
    localparam int AW = 4;

`ifdef REG_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*WS-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [WS-1:0]   rdata;

    reg_access_arbiter #(
        .WORD_SIZE (WS),
        .NUM_REGS  (NR),
        .ADDR_W    (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [WS-1:0] d0;
        logic [WS-1:0] d1;
        logic [1:0]    g_rr;
        logic [1:0]    g_fx;
    } vec_t;

    typedef struct {
        logic [1:0]    rvalid;
        logic [WS-1:0] rdata;
    } rsp_t;

    vec_t          tv [17];
    rsp_t          sb_q [$];
    logic [WS-1:0] mbank [NR];
    logic [WS-1:0] mlast;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mbank[i] = '0;
        mlast = '0;
        sb_q.delete();
    endtask

    function automatic logic [1:0] pick(input logic [1:0] g_rr, input logic [1:0] g_fx);
        return RR ? g_rr : g_fx;
    endfunction

    // One transaction cycle: drive, check grant, queue the expected response,
    // then compare the registered response after the clock edge.
    task automatic cycle(input string name, input logic [1:0] r, input logic [1:0] w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [WS-1:0] d0, input logic [WS-1:0] d1,
                         input logic [1:0] eg);
        rsp_t e;
        rsp_t got;
        int   who;
        int   ai;
        @(negedge clk);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #1;
        check({name, ".gnt"}, 64'(gnt), 64'(eg));
        e.rvalid = 2'b00;
        e.rdata  = mlast;
        if (eg != 2'b00) begin
            who = eg[1] ? 1 : 0;
            ai  = int'(who ? a1 : a0);
            if (w[who]) begin
                if (ai < NR) mbank[ai] = who ? d1 : d0;
            end else begin
                e.rvalid = eg;
                e.rdata  = (ai < NR) ? mbank[ai] : '0;
                mlast    = e.rdata;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got.rvalid = rvalid;
        got.rdata  = rdata;
        e = sb_q.pop_front();
        check({name, ".rvalid"}, 64'(got.rvalid), 64'(e.rvalid));
        check({name, ".rdata"}, 64'(got.rdata), 64'(e.rdata));
        $display("txn %-12s req=%b we=%b a0=%0d a1=%0d gnt=%b -> rvalid=%b rdata=%08h",
                 name, r, w, a0, a1, eg, got.rvalid, got.rdata);
    endtask

    initial begin
        // req, we, a0, a1, d0, d1, gnt(round-robin), gnt(fixed)
        tv[0]  = '{2'b11, 2'b00, 4'd1, 4'd1, 32'h0,         32'h0,         2'b01, 2'b01};
        tv[1]  = '{2'b11, 2'b00, 4'd1, 4'd1, 32'h0,         32'h0,         2'b10, 2'b01};
        tv[2]  = '{2'b11, 2'b00, 4'd1, 4'd1, 32'h0,         32'h0,         2'b01, 2'b01};
        tv[3]  = '{2'b11, 2'b00, 4'd1, 4'd1, 32'h0,         32'h0,         2'b10, 2'b01};
        tv[4]  = '{2'b01, 2'b01, 4'd2, 4'd0, 32'hDEADBEEF,  32'h0,         2'b01, 2'b01};
        tv[5]  = '{2'b01, 2'b00, 4'd2, 4'd0, 32'h0,         32'h0,         2'b01, 2'b01};
        tv[6]  = '{2'b10, 2'b10, 4'd0, 4'd5, 32'h0,         32'hA5A50001,  2'b10, 2'b10};
        tv[7]  = '{2'b01, 2'b01, 4'd1, 4'd0, 32'hCAFEF00D,  32'h0,         2'b01, 2'b01};
        tv[8]  = '{2'b11, 2'b11, 4'd4, 4'd6, 32'h11111111,  32'h22222222,  2'b10, 2'b01};
        tv[9]  = '{2'b11, 2'b11, 4'd4, 4'd6, 32'h11111111,  32'h22222222,  2'b01, 2'b01};
        tv[10] = '{2'b11, 2'b00, 4'd6, 4'd4, 32'h0,         32'h0,         2'b10, 2'b01};
        tv[11] = '{2'b10, 2'b10, 4'd0, 4'd9, 32'h0,         32'h00001234,  2'b10, 2'b10};
        tv[12] = '{2'b10, 2'b00, 4'd0, 4'd9, 32'h0,         32'h0,         2'b10, 2'b10};
        tv[13] = '{2'b01, 2'b00, 4'd1, 4'd0, 32'h0,         32'h0,         2'b01, 2'b01};
        tv[14] = '{2'b01, 2'b00, 4'd5, 4'd0, 32'h0,         32'h0,         2'b01, 2'b01};
        tv[15] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,         32'h0,         2'b00, 2'b00};
        tv[16] = '{2'b11, 2'b00, 4'd7, 4'd0, 32'h0,         32'h0,         2'b10, 2'b01};

        // Reset with both requesting: nothing granted, outputs cleared.
        rst   = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;
        model_reset();
        #1;
        check("rst.gnt", 64'(gnt), 64'd0);
        check("rst.rvalid", 64'(rvalid), 64'd0);
        check("rst.rdata", 64'(rdata), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;

        for (int k = 0; k < 17; k++) begin
            cycle($sformatf("v%0d", k), tv[k].req, tv[k].we, tv[k].a0, tv[k].a1,
                  tv[k].d0, tv[k].d1, pick(tv[k].g_rr, tv[k].g_fx));
        end

        // Reset in the middle of traffic with a read pending.
        cycle("w55_a3", 2'b01, 2'b01, 4'd3, 4'd0, 32'h55, 32'h0, 2'b01);
        cycle("rd_a3", 2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 2'b01);
        @(negedge clk);
        req  = 2'b01;
        we   = 2'b00;
        addr = {4'd0, 4'd3};
        rst  = 1'b1;
        #1;
        check("midrst.gnt", 64'(gnt), 64'd0);
        check("midrst.rvalid", 64'(rvalid), 64'd0);
        check("midrst.rdata", 64'(rdata), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("midrst.rvalid_edge", 64'(rvalid), 64'd0);
        check("midrst.gnt_edge", 64'(gnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        cycle("post_rd_a3", 2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 2'b01);

        // Requester 1 withdraws a losing write request.
        cycle("r1_only", 2'b10, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 2'b10);
        cycle("wd_a", 2'b11, 2'b10, 4'd0, 4'd3, 32'h0, 32'h77, 2'b01);
        cycle("wd_b", 2'b01, 2'b00, 4'd0, 4'd3, 32'h0, 32'h77, 2'b01);
        cycle("wd_c", 2'b11, 2'b00, 4'd2, 4'd3, 32'h0, 32'h0, pick(2'b10, 2'b01));
        cycle("wd_d", 2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
